// File: rtl/spi_receive_con_if.sv
// Link pins from the peripheral sender plus the reconstructed pixel stream.
// slave = receiver side, master = whoever drives the link and consumes pixels.
interface spi_receive_con_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int H_PIXELS   = 320,
  parameter int V_PIXELS   = 180
);
  logic [LINES-1:0]            chip_data_in;
  logic                        chip_clk_in;
  logic                        chip_sel_in;
  logic                        final_pixel_in;
  logic                        pixel_valid_out;
  logic [DATA_WIDTH-1:0]       pixel_data_out;
  logic [$clog2(H_PIXELS)-1:0] hcount_out;
  logic [$clog2(V_PIXELS)-1:0] vcount_out;
  logic                        frame_done_out;
  logic                        frame_error_out;
  logic [15:0]                 frame_count_out;

  modport slave (
    input  chip_data_in, chip_clk_in, chip_sel_in, final_pixel_in,
    output pixel_valid_out, pixel_data_out, hcount_out, vcount_out,
           frame_done_out, frame_error_out, frame_count_out
  );

  modport master (
    output chip_data_in, chip_clk_in, chip_sel_in, final_pixel_in,
    input  pixel_valid_out, pixel_data_out, hcount_out, vcount_out,
           frame_done_out, frame_error_out, frame_count_out
  );
endinterface

// File: rtl/spi_receive_con.sv
// Quad-line pixel link receiver: synchronizes the link pins, deserializes
// MSB-first nibbles into pixels and tracks frame position / alignment.
module spi_receive_con #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINES       = 4,
  parameter int H_PIXELS    = 320,
  parameter int V_PIXELS    = 180,
  parameter int SYNC_STAGES = 2
)(
  input logic              clk_in,
  input logic              rst_n_in,
  spi_receive_con_if.slave link
);
  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW    = $clog2(H_PIXELS);
  localparam int VW    = $clog2(V_PIXELS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_PIXELS - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0]            clk_sync, sel_sync, fin_sync;
  logic [SYNC_STAGES-1:0][LINES-1:0] dat_sync;
  logic                              dclk_s, cs_s, fin_s, dclk_q;
  logic [LINES-1:0]                  dat_s;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync <= '0;
      sel_sync <= '1;
      fin_sync <= '0;
      dat_sync <= '0;
      dclk_q   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], link.chip_clk_in};
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], link.chip_sel_in};
      fin_sync <= {fin_sync[SYNC_STAGES-2:0], link.final_pixel_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], link.chip_data_in};
      dclk_q   <= dclk_s;
    end
  end

  assign dclk_s = clk_sync[SYNC_STAGES-1];
  assign cs_s   = sel_sync[SYNC_STAGES-1];
  assign fin_s  = fin_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];

  state_t          state, state_nxt;
  logic [BW-1:0]   beat;
  logic            sample, last_smp, abort;

  assign sample   = dclk_s & ~dclk_q & ~cs_s;
  assign last_smp = sample && (beat == LAST_BEAT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Select dropping with a partially received pixel is a framing fault.
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE: if (!cs_s) state_nxt = RECV;
      RECV: if (cs_s) begin
        state_nxt = IDLE;
        abort     = (beat != '0);
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] shreg;
  logic                  pend, pend_fin;

  // beat is always 0 in IDLE: it only leaves RECV through abort or a completed pixel
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      beat     <= '0;
      shreg    <= '0;
      pend     <= 1'b0;
      pend_fin <= 1'b0;
    end else begin
      pend     <= last_smp;
      pend_fin <= last_smp & fin_s;
      if (abort)
        beat <= '0;
      else if (sample)
        beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      if (sample)
        shreg <= (shreg << LINES) | DATA_WIDTH'(dat_s);
    end
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          at_last;

  assign at_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_cnt                <= '0;
      v_cnt                <= '0;
      link.pixel_valid_out <= 1'b0;
      link.pixel_data_out  <= '0;
      link.hcount_out      <= '0;
      link.vcount_out      <= '0;
      link.frame_done_out  <= 1'b0;
      link.frame_error_out <= 1'b0;
      link.frame_count_out <= '0;
    end else begin
      link.pixel_valid_out <= pend;
      link.frame_done_out  <= pend & pend_fin;
      if (abort) link.frame_error_out <= 1'b1;
      if (pend) begin
        link.pixel_data_out <= shreg;
        link.hcount_out     <= h_cnt;
        link.vcount_out     <= v_cnt;
        // Last flag resyncs position; frame count bumps once either way.
        if (pend_fin || at_last) begin
          h_cnt                <= '0;
          v_cnt                <= '0;
          link.frame_count_out <= link.frame_count_out + 16'd1;
          if (pend_fin && !at_last) link.frame_error_out <= 1'b1;
        end else if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
    end
  end
endmodule

// File: doc/spi_receive_con.md
Name: spi_receive_con

Overview:
- Receiver end of the quad-line pixel SPI link driven by the peripheral FPGA's sender, which provides dclk, 4 data lines, active-low chip select and a last-pixel flag.
- Sits on the main FPGA. Synchronizes the asynchronous link pins into clk_in and deserializes MSB-first nibbles into DATA_WIDTH-bit pixels.
- Reconstructs the pixel's hcount/vcount and emits one-cycle valid pulses for downstream frame-buffer writes.
- Checks frame alignment against the last-pixel flag.

Parameters:
- DATA_WIDTH, 8, bits per pixel; must be a multiple of LINES.
- LINES, 4, number of parallel data lines.
- H_PIXELS, 320, pixels per row.
- V_PIXELS, 180, rows per frame.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).

Ports:
- clk_in  input  1  system clock; must run at ≥4x dclk frequency.
- rst_n_in  input  1  asynchronous active-low reset.
- chip_data_in  input  LINES  data lines, asynchronous.
- chip_clk_in  input  1  link data clock (dclk), asynchronous.
- chip_sel_in  input  1  chip select, active low, asynchronous.
- final_pixel_in  input  1  high during the beats of the frame's last pixel, asynchronous.
- pixel_valid_out  output  1  one-cycle pulse; pixel fields valid.
- pixel_data_out  output  DATA_WIDTH  received pixel.
- hcount_out  output  $clog2(H_PIXELS)  column of the pixel.
- vcount_out  output  $clog2(V_PIXELS)  row of the pixel.
- frame_done_out  output  1  pulses together with pixel_valid_out on a pixel flagged last.
- frame_error_out  output  1  sticky; set on misaligned last flag or mid-pixel select drop.
- frame_count_out  output  16  count of completed frames, wraps.

Behaviour:
- Synchronizers
  - All four link inputs pass through SYNC_STAGES flops.
  - Reset values: dclk 0, cs 1, data 0, final 0.
- Sampling
  - A sample is taken in the cycle where synced dclk shows a rising edge (previous 0, current 1) while synced cs = 0.
  - The sample captures synced data and synced final in that cycle.
- Deserialization
  - BEATS = DATA_WIDTH/LINES (2 at default).
  - The first beat is the MSB nibble; the shift register shifts left by LINES each sample.
  - A beat counter counts 0..BEATS-1.
- FSM states: IDLE, RECV.
  - IDLE → RECV on synced cs falling to 0; beat counter cleared.
  - RECV → IDLE on synced cs = 1.
  - If cs rises with beat counter ≠ 0: partial pixel discarded, no valid pulse, frame_error_out set, h/v counters unchanged.
- Output timing
  - On the final-beat sample, the outputs register next cycle: pixel_valid_out = 1 with assembled data and the current h/v counts.
  - Pin-to-valid latency is SYNC_STAGES+2 clk_in cycles after the dclk edge.
  - All outputs are registered.
- Counters
  - After each pixel, hcount increments.
  - At H_PIXELS-1, hcount wraps to 0 and vcount increments.
  - At (H_PIXELS-1, V_PIXELS-1), both wrap to 0 and frame_count increments.
- Last flag
  - If final was sampled on the final beat of a pixel: frame_done_out pulses with the pixel and h/v reset to 0 afterward.
  - frame_count increments once only, even if the position also wrapped.
  - If that pixel's position ≠ (H_PIXELS-1, V_PIXELS-1), frame_error_out is set (resync).
  - If counters wrap at the last position without the flag, frame_count still increments and no error is flagged.
- Reset values, all outputs: valid 0, data 0, counts 0, frame_done 0, error 0, frame_count 0. FSM → IDLE.
- Reset mid-pixel discards the partial pixel. frame_error_out is cleared only by reset.
- dclk edges while cs = 1 are ignored.

Test Plan:
- Select low, nibbles 0xA then 0x5 at dclk = 1/6 clk_in → pixel_valid_out once, data 0xA5, h = 0, v = 0, latency SYNC_STAGES+2 cycles after the 2nd edge.
- 320 pixels streamed with increasing data → last pixel h = 319, v = 0; next pixel h = 0, v = 1.
- Full 57600-pixel frame with final on the last pixel → frame_done_out pulses once at (319,179), frame_count_out = 1, frame_error_out = 0.
- final asserted at pixel (10,3) → frame_done pulse, frame_error_out = 1; next pixel reported at h = 0, v = 0.
- cs raised after the first nibble → no valid pulse, frame_error_out = 1; the following full pixel arrives with the unchanged h/v.
- rst_n_in pulsed low mid-frame, asynchronous to clk_in → all outputs 0 immediately; the next pixel is reported at (0,0).
